// File: rtl/drmem_arb2_pkg.sv
// rtl/drmem_arb2_pkg.sv - shared constants and types for the DR-to-memory arbiter
//
// Purpose: payload widths, tag position, directory-slice id and stats width
//          used by drmem_arb2, drmem_rr2 and drmem_arb2_if.
// Ports:   none (package).
// Optional feature macro: DRMEM_ARB_STATS_EN (consumed by drmem_arb2).
package drmem_arb2_pkg;

  localparam int REQ_W   = 64;          // flattened I_drtomem_req_type
  localparam int ACK_W   = 64;          // flattened I_memtodr_ack_type
  localparam int TAG_W   = 4;           // request/ack tag width
  localparam int TAG_LSB = 0;           // tag sits in payload bits [TAG_LSB +: TAG_W]
  localparam int NTAG    = 1 << TAG_W;  // outstanding-tag table depth
  localparam int STAT_W  = 16;          // grant counter width

  typedef enum logic {
    DR0 = 1'b0,
    DR1 = 1'b1
  } dr_id_e;

  function automatic dr_id_e other_dr(input dr_id_e id);
    return (id == DR0) ? DR1 : DR0;
  endfunction

endpackage

// File: rtl/drmem_arb2_if.sv
// rtl/drmem_arb2_if.sv - bundle of all arbiter-facing handshake channels
//
// Purpose: groups the two directory request/ack channels, the memory
//          request/ack channels and the orphan-ack error flag.
// Modports:
//   slave  - the arbiter (drmem_arb2) side.
//   master - the environment side (directory slices and memory).
interface drmem_arb2_if;
  import drmem_arb2_pkg::*;

  logic             dr0_req_valid, dr0_req_retry;
  logic [REQ_W-1:0] dr0_req;
  logic             dr1_req_valid, dr1_req_retry;
  logic [REQ_W-1:0] dr1_req;
  logic             drtomem_req_valid, drtomem_req_retry;
  logic [REQ_W-1:0] drtomem_req;
  logic             memtodr_ack_valid, memtodr_ack_retry;
  logic [ACK_W-1:0] memtodr_ack;
  logic             dr0_ack_valid, dr0_ack_retry;
  logic [ACK_W-1:0] dr0_ack;
  logic             dr1_ack_valid, dr1_ack_retry;
  logic [ACK_W-1:0] dr1_ack;
  logic             err_orphan_ack;

  modport slave (
    input  dr0_req_valid, dr0_req, dr1_req_valid, dr1_req,
    output dr0_req_retry, dr1_req_retry,
    output drtomem_req_valid, drtomem_req,
    input  drtomem_req_retry,
    input  memtodr_ack_valid, memtodr_ack,
    output memtodr_ack_retry,
    output dr0_ack_valid, dr0_ack, dr1_ack_valid, dr1_ack,
    input  dr0_ack_retry, dr1_ack_retry,
    output err_orphan_ack
  );

  modport master (
    output dr0_req_valid, dr0_req, dr1_req_valid, dr1_req,
    input  dr0_req_retry, dr1_req_retry,
    input  drtomem_req_valid, drtomem_req,
    output drtomem_req_retry,
    output memtodr_ack_valid, memtodr_ack,
    input  memtodr_ack_retry,
    input  dr0_ack_valid, dr0_ack, dr1_ack_valid, dr1_ack,
    output dr0_ack_retry, dr1_ack_retry,
    input  err_orphan_ack
  );

endinterface

// File: rtl/drmem_rr2.sv
// rtl/drmem_rr2.sv - two-input round-robin arbiter
//
// Purpose: grants one of two eligible requesters; the pointer side wins a tie
//          and the pointer always moves to the side opposite the winner.
// Ports:
//   clk     - clock
//   reset   - synchronous active-low reset (pointer -> DR0)
//   elig_i  - per-side eligibility, bit n = DRn
//   gnt_o   - one-hot grant (combinational), bit n = DRn
module drmem_rr2
  import drmem_arb2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o
);

  dr_id_e ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (elig_i == 2'b11) begin
      gnt_o = (ptr_q == DR0) ? 2'b01 : 2'b10;
      ptr_d = other_dr(ptr_q);
    end else if (elig_i[0]) begin
      gnt_o = 2'b01;
      ptr_d = DR1;
    end else if (elig_i[1]) begin
      gnt_o = 2'b10;
      ptr_d = DR0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= DR0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/drmem_arb2.sv
// rtl/drmem_arb2.sv - shares the memory request port between DR0/DR1 and routes acks
//
// Purpose: one-entry registered request buffer fed by a round-robin arbiter,
//          an outstanding-tag table (busy/owner) and a one-entry ack buffer
//          that returns each ack to the slice that issued the tag.
// Ports:
//   clk      - clock
//   reset    - synchronous active-low reset
//   bus      - drmem_arb2_if.slave: DR request/ack channels, memory request/ack
//              channels, sticky err_orphan_ack
//   gnt_cnt0 - (DRMEM_ARB_STATS_EN only) saturating count of DR0 accepts
//   gnt_cnt1 - (DRMEM_ARB_STATS_EN only) saturating count of DR1 accepts
module drmem_arb2
  import drmem_arb2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  drmem_arb2_if.slave       bus
`ifdef DRMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] gnt_cnt0,
  output logic [STAT_W-1:0] gnt_cnt1
`endif
);

  logic             req_vld_q, req_vld_d;
  logic [REQ_W-1:0] req_q, req_d;
  logic             ack_vld_q, ack_vld_d;
  logic [ACK_W-1:0] ack_q, ack_d;
  dr_id_e           ack_dst_q, ack_dst_d;
  logic [NTAG-1:0]  busy_q, busy_d;
  logic [NTAG-1:0]  owner_q, owner_d;   // 1 = DR1 owns the tag
  logic             err_q, err_d;

  logic [TAG_W-1:0] tag0, tag1, win_tag, ack_tag;
  logic             req_can_acc, ack_dst_retry, ack_drain, ack_cap;
  logic [1:0]       elig, gnt;

  assign tag0    = bus.dr0_req[TAG_LSB +: TAG_W];
  assign tag1    = bus.dr1_req[TAG_LSB +: TAG_W];
  assign ack_tag = bus.memtodr_ack[TAG_LSB +: TAG_W];
  assign win_tag = gnt[1] ? tag1 : tag0;

  // Buffer accepts when empty or draining, giving full throughput.
  assign req_can_acc = !req_vld_q || !bus.drtomem_req_retry;

  // Eligibility uses registered busy only: a tag freed by an ack this cycle
  // is still seen busy, so the request naturally retries once.
  assign elig[0] = reset && bus.dr0_req_valid && req_can_acc && !busy_q[tag0];
  assign elig[1] = reset && bus.dr1_req_valid && req_can_acc && !busy_q[tag1];

  drmem_rr2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .elig_i (elig),
    .gnt_o  (gnt)
  );

  assign ack_dst_retry = (ack_dst_q == DR0) ? bus.dr0_ack_retry : bus.dr1_ack_retry;
  assign ack_drain     = ack_vld_q && !ack_dst_retry;
  assign ack_cap       = bus.memtodr_ack_valid && !bus.memtodr_ack_retry;

  assign bus.dr0_req_retry     = !gnt[0];
  assign bus.dr1_req_retry     = !gnt[1];
  assign bus.drtomem_req_valid = req_vld_q;
  assign bus.drtomem_req       = req_q;
  assign bus.memtodr_ack_retry = !reset || (ack_vld_q && ack_dst_retry);
  assign bus.dr0_ack_valid     = ack_vld_q && (ack_dst_q == DR0);
  assign bus.dr1_ack_valid     = ack_vld_q && (ack_dst_q == DR1);
  assign bus.dr0_ack           = ack_q;
  assign bus.dr1_ack           = ack_q;
  assign bus.err_orphan_ack    = err_q;

  always_comb begin
    req_vld_d = req_vld_q && bus.drtomem_req_retry;
    req_d     = req_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    ack_vld_d = ack_vld_q && !ack_drain;
    ack_d     = ack_q;
    ack_dst_d = ack_dst_q;
    err_d     = err_q;

    if (|gnt) begin
      req_vld_d        = 1'b1;
      req_d            = gnt[1] ? bus.dr1_req : bus.dr0_req;
      busy_d[win_tag]  = 1'b1;
      owner_d[win_tag] = gnt[1];
    end

    // Allocation only hits free tags and clearing only hits busy ones, so the
    // two updates never collide on the same entry.
    if (ack_cap) begin
      if (busy_q[ack_tag]) begin
        busy_d[ack_tag] = 1'b0;
        ack_vld_d       = 1'b1;
        ack_d           = bus.memtodr_ack;
        ack_dst_d       = dr_id_e'(owner_q[ack_tag]);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_vld_q <= 1'b0;
      req_q     <= '0;
      ack_vld_q <= 1'b0;
      ack_q     <= '0;
      ack_dst_q <= DR0;
      busy_q    <= '0;
      owner_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      req_vld_q <= req_vld_d;
      req_q     <= req_d;
      ack_vld_q <= ack_vld_d;
      ack_q     <= ack_d;
      ack_dst_q <= ack_dst_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
    end
  end

`ifdef DRMEM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  assign cnt0_d = (gnt[0] && (cnt0_q != '1)) ? cnt0_q + STAT_W'(1) : cnt0_q;
  assign cnt1_d = (gnt[1] && (cnt1_q != '1)) ? cnt1_q + STAT_W'(1) : cnt1_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_drmem_arb2.sv
// tb/tb_drmem_arb2.sv - directed self-checking bench for drmem_arb2
module tb_drmem_arb2;
  import drmem_arb2_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  drmem_arb2_if bus ();

  drmem_arb2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [31:0] hi, input logic [3:0] tag);
    return {hi, 28'h0, tag};
  endfunction

  logic [3:0] t0 [0:2];
  logic [3:0] t1 [0:2];
  logic [3:0] exp_seq [0:5];
  int i0, i1;
  logic a0, a1;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    t0 = '{4'd1, 4'd2, 4'd3};
    t1 = '{4'd8, 4'd9, 4'd10};
    exp_seq = '{4'd1, 4'd8, 4'd2, 4'd9, 4'd3, 4'd10};

    // Reset with every input active.
    reset                 = 1'b0;
    bus.dr0_req_valid     = 1'b1;
    bus.dr0_req           = mk(32'hD0, 4'd1);
    bus.dr1_req_valid     = 1'b1;
    bus.dr1_req           = mk(32'hD1, 4'd8);
    bus.drtomem_req_retry = 1'b0;
    bus.memtodr_ack_valid = 1'b1;
    bus.memtodr_ack       = mk(32'hA0, 4'd0);
    bus.dr0_ack_retry     = 1'b0;
    bus.dr1_ack_retry     = 1'b0;
    repeat (3) tick();
    check_eq("rst_req_valid", 64'(bus.drtomem_req_valid), 64'd0);
    check_eq("rst_dr0_ack_valid", 64'(bus.dr0_ack_valid), 64'd0);
    check_eq("rst_dr1_ack_valid", 64'(bus.dr1_ack_valid), 64'd0);
    check_eq("rst_dr0_retry", 64'(bus.dr0_req_retry), 64'd1);
    check_eq("rst_dr1_retry", 64'(bus.dr1_req_retry), 64'd1);
    check_eq("rst_ack_retry", 64'(bus.memtodr_ack_retry), 64'd1);
    check_eq("rst_err", 64'(bus.err_orphan_ack), 64'd0);

    // Contention: expect 1,8,2,9,3,10 back to back, DR0 first.
    bus.memtodr_ack_valid = 1'b0;
    reset = 1'b1;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 7; c++) begin
      bus.dr0_req_valid = (i0 < 3);
      bus.dr1_req_valid = (i1 < 3);
      if (i0 < 3) bus.dr0_req = mk(32'hD0, t0[i0]);
      if (i1 < 3) bus.dr1_req = mk(32'hD1, t1[i1]);
      #1;
      a0 = bus.dr0_req_valid && !bus.dr0_req_retry;
      a1 = bus.dr1_req_valid && !bus.dr1_req_retry;
      if (c == 0) begin
        check_eq("first_gnt_dr0_retry", 64'(bus.dr0_req_retry), 64'd0);
        check_eq("first_gnt_dr1_retry", 64'(bus.dr1_req_retry), 64'd1);
      end else begin
        check_eq("rr_valid", 64'(bus.drtomem_req_valid), 64'd1);
        check_eq("rr_payload", bus.drtomem_req,
                 mk((exp_seq[c-1] < 4'd8) ? 32'hD0 : 32'hD1, exp_seq[c-1]));
      end
      tick();
      if (a0) i0++;
      if (a1) i1++;
    end
    check_eq("rr_drained", 64'(bus.drtomem_req_valid), 64'd0);

    // Memory stall with DR0 tag 4 buffered.
    bus.drtomem_req_retry = 1'b1;
    bus.dr0_req_valid     = 1'b1;
    bus.dr0_req           = mk(32'hD0, 4'd4);
    bus.dr1_req_valid     = 1'b1;
    bus.dr1_req           = mk(32'hD1, 4'd11);
    #1;
    check_eq("stall_acc_dr0", 64'(bus.dr0_req_retry), 64'd0);
    tick();
    bus.dr0_req = mk(32'hD0, 4'd12);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("stall_valid", 64'(bus.drtomem_req_valid), 64'd1);
      check_eq("stall_payload", bus.drtomem_req, mk(32'hD0, 4'd4));
      check_eq("stall_dr0_retry", 64'(bus.dr0_req_retry), 64'd1);
      check_eq("stall_dr1_retry", 64'(bus.dr1_req_retry), 64'd1);
      tick();
    end
    bus.drtomem_req_retry = 1'b0;
    #1;
    check_eq("drain_dr1_gnt", 64'(bus.dr1_req_retry), 64'd0);
    check_eq("drain_dr0_lose", 64'(bus.dr0_req_retry), 64'd1);
    tick();
    bus.dr1_req_valid = 1'b0;
    #1;
    check_eq("drain_next_payload", bus.drtomem_req, mk(32'hD1, 4'd11));
    check_eq("drain_dr0_gnt", 64'(bus.dr0_req_retry), 64'd0);
    tick();
    bus.dr0_req_valid = 1'b0;
    #1;
    check_eq("drain_dr0_payload", bus.drtomem_req, mk(32'hD0, 4'd12));
    tick();

    // Routing: DR1 tag 5, then its ack; then ack back-pressure.
    bus.dr1_req_valid = 1'b1;
    bus.dr1_req       = mk(32'hD1, 4'd5);
    #1;
    check_eq("route_req_acc", 64'(bus.dr1_req_retry), 64'd0);
    tick();
    bus.dr1_req_valid     = 1'b0;
    bus.memtodr_ack_valid = 1'b1;
    bus.memtodr_ack       = mk(32'hA5, 4'd5);
    #1;
    check_eq("route_ack_acc", 64'(bus.memtodr_ack_retry), 64'd0);
    tick();
    bus.memtodr_ack_valid = 1'b0;
    #1;
    check_eq("route_dr1_valid", 64'(bus.dr1_ack_valid), 64'd1);
    check_eq("route_dr1_ack", bus.dr1_ack, mk(32'hA5, 4'd5));
    check_eq("route_dr0_valid", 64'(bus.dr0_ack_valid), 64'd0);
    bus.dr1_ack_retry     = 1'b1;
    bus.memtodr_ack_valid = 1'b1;
    bus.memtodr_ack       = mk(32'hA6, 4'd11);
    #1;
    check_eq("ack_bp", 64'(bus.memtodr_ack_retry), 64'd1);
    tick();
    check_eq("ack_hold", bus.dr1_ack, mk(32'hA5, 4'd5));
    check_eq("ack_hold_valid", 64'(bus.dr1_ack_valid), 64'd1);
    bus.dr1_ack_retry = 1'b0;
    #1;
    check_eq("ack_bp_release", 64'(bus.memtodr_ack_retry), 64'd0);
    tick();
    bus.memtodr_ack = mk(32'hA7, 4'd4);
    #1;
    check_eq("ack11_dr1", bus.dr1_ack, mk(32'hA6, 4'd11));
    check_eq("ack11_dr0_valid", 64'(bus.dr0_ack_valid), 64'd0);
    tick();
    bus.memtodr_ack_valid = 1'b0;
    #1;
    check_eq("ack4_dr0_valid", 64'(bus.dr0_ack_valid), 64'd1);
    check_eq("ack4_dr0", bus.dr0_ack, mk(32'hA7, 4'd4));
    check_eq("ack4_dr1_valid", 64'(bus.dr1_ack_valid), 64'd0);
    tick();

    // Tag collision on tag 6.
    bus.dr0_req_valid = 1'b1;
    bus.dr0_req       = mk(32'hD0, 4'd6);
    #1;
    check_eq("coll_dr0_acc", 64'(bus.dr0_req_retry), 64'd0);
    tick();
    bus.dr0_req_valid = 1'b0;
    bus.dr1_req_valid = 1'b1;
    bus.dr1_req       = mk(32'hD1, 4'd6);
    #1;
    check_eq("coll_busy", 64'(bus.dr1_req_retry), 64'd1);
    tick();
    check_eq("coll_busy2", 64'(bus.dr1_req_retry), 64'd1);
    bus.memtodr_ack_valid = 1'b1;
    bus.memtodr_ack       = mk(32'hA8, 4'd6);
    #1;
    check_eq("coll_same_cyc", 64'(bus.dr1_req_retry), 64'd1);
    check_eq("coll_ack_acc", 64'(bus.memtodr_ack_retry), 64'd0);
    tick();
    bus.memtodr_ack_valid = 1'b0;
    #1;
    check_eq("coll_free", 64'(bus.dr1_req_retry), 64'd0);
    check_eq("coll_ack_dr0", 64'(bus.dr0_ack_valid), 64'd1);
    tick();
    bus.dr1_req_valid = 1'b0;
    #1;
    check_eq("coll_payload", bus.drtomem_req, mk(32'hD1, 4'd6));
    tick();

    // Orphan ack on tag 7.
    bus.memtodr_ack_valid = 1'b1;
    bus.memtodr_ack       = mk(32'hA9, 4'd7);
    #1;
    check_eq("orph_acc", 64'(bus.memtodr_ack_retry), 64'd0);
    check_eq("orph_err_before", 64'(bus.err_orphan_ack), 64'd0);
    tick();
    bus.memtodr_ack_valid = 1'b0;
    #1;
    check_eq("orph_err", 64'(bus.err_orphan_ack), 64'd1);
    check_eq("orph_drop0", 64'(bus.dr0_ack_valid), 64'd0);
    check_eq("orph_drop1", 64'(bus.dr1_ack_valid), 64'd0);
    repeat (4) tick();
    check_eq("orph_sticky", 64'(bus.err_orphan_ack), 64'd1);
    reset = 1'b0;
    tick();
    check_eq("orph_rst_err", 64'(bus.err_orphan_ack), 64'd0);
    check_eq("orph_rst_valid", 64'(bus.drtomem_req_valid), 64'd0);
    check_eq("orph_rst_ack_retry", 64'(bus.memtodr_ack_retry), 64'd1);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
